// File: rtl/vm_pkg.sv
// vm_pkg: shared types and constants for the vending dispense controller.
//   vm_state_e : controller state encoding
//   COIN_*     : coin-unit codes seen on cash_return
//   PRICE_DEF  : default item price in coin units
//   CHG_W      : change-counter width (holds up to cash_return + PRICE = 6)
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        CHG_REQ,
        CHG_REL,
        HALT
    } vm_state_e;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_2    = 2'd2;

    localparam int PRICE_DEF = 3;
    localparam int CHG_W     = 3;

endpackage

// File: rtl/vm_hopper_if.sv
// vm_hopper_if: change hopper sequencer.
// Holds the change owed and pays it out one coin per 4-phase handshake:
// raise coin_pulse, wait hopper_ack=1, drop coin_pulse (coin counted),
// wait hopper_ack=0, repeat while change remains.
// Ports:
//   clk, rst        clock, async active-low reset
//   load, load_val  overwrite the change counter
//   start           begin paying out (issued with the first request)
//   hopper_ack      hopper acknowledge
//   coin_pulse      registered hopper request
//   chg             change still owed
//   done            release phase complete with nothing left to pay
module vm_hopper_if
    import vm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CHG_W-1:0] load_val,
    input  logic             start,
    input  logic             hopper_ack,
    output logic             coin_pulse,
    output logic [CHG_W-1:0] chg,
    output logic             done
);

    logic active;
    logic paid;

    assign paid = coin_pulse & hopper_ack;
    // Release phase is "active with the request low"; no separate flag needed.
    assign done = active & ~coin_pulse & ~hopper_ack & (chg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg        <= '0;
            coin_pulse <= 1'b0;
            active     <= 1'b0;
        end else begin
            if (load)
                chg <= load_val;
            else if (paid)
                chg <= chg - CHG_W'(1);

            if (start) begin
                coin_pulse <= 1'b1;
                active     <= 1'b1;
            end else if (paid) begin
                coin_pulse <= 1'b0;
            end else if (active && !coin_pulse && !hopper_ack) begin
                if (chg == '0)
                    active <= 1'b0;
                else
                    coin_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// vm_dispense_ctrl: sequences the dispense motor and change hopper behind
// the vending FSM, tracks stock, refunds on sold-out / motor timeout and
// gates coin acceptance while a transaction is in flight.
// Optional build macro VM_AUDIT_EN adds sales_count / refund_count outputs.
// Ports:
//   clk, rst                 clock, async active-low reset
//   purchase, cash_return    one-cycle event from the vending FSM
//   motor_on, motor_done     motor drive / end-of-travel sensor
//   coin_pulse, hopper_ack   hopper handshake
//   coin_accept_en, busy     upstream throttle / transaction in progress
//   sold_out, stock_level    stock status
//   fault, overrun           sticky motor timeout / dropped event flags
//   restock, restock_qty     saturating stock top-up (IDLE only)
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 10,
    parameter int PRICE         = PRICE_DEF,
    parameter int MOTOR_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               purchase,
    input  logic [1:0]         cash_return,
    output logic               motor_on,
    input  logic               motor_done,
    output logic               coin_pulse,
    input  logic               hopper_ack,
    output logic               coin_accept_en,
    output logic               busy,
    output logic               sold_out,
    output logic               fault,
    output logic               overrun,
    output logic [STOCK_W-1:0] stock_level,
    input  logic               restock,
    input  logic [STOCK_W-1:0] restock_qty
`ifdef VM_AUDIT_EN
    ,
    output logic [15:0]        sales_count,
    output logic [15:0]        refund_count
`endif
);

    localparam int TMR_W = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

    vm_state_e        state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic [STOCK_W-1:0] stock_nxt;
    logic [STOCK_W:0] restock_sum;
    logic             fault_nxt, overrun_nxt;
    logic             event_in;
    logic             hop_load, hop_start, hop_done;
    logic [CHG_W-1:0] hop_load_val, chg;

    assign event_in    = purchase | (cash_return != COIN_NONE);
    assign restock_sum = {1'b0, stock_level} + {1'b0, restock_qty};

    vm_hopper_if u_hopper (
        .clk        (clk),
        .rst        (rst),
        .load       (hop_load),
        .load_val   (hop_load_val),
        .start      (hop_start),
        .hopper_ack (hopper_ack),
        .coin_pulse (coin_pulse),
        .chg        (chg),
        .done       (hop_done)
    );

    always_comb begin
        state_nxt    = state;
        stock_nxt    = stock_level;
        fault_nxt    = fault;
        overrun_nxt  = overrun;
        hop_load     = 1'b0;
        hop_start    = 1'b0;
        hop_load_val = CHG_W'(cash_return);

        // Anything from upstream outside IDLE is lost; HALT included.
        if (state != IDLE && event_in)
            overrun_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (purchase) begin
                    // Purchase beats a same-cycle restock.
                    if (restock)
                        overrun_nxt = 1'b1;
                    hop_load = 1'b1;
                    if (stock_level != '0) begin
                        state_nxt = VEND;
                    end else begin
                        // Sold out: refund the price along with the change.
                        hop_load_val = CHG_W'(cash_return) + CHG_W'(PRICE);
                        hop_start    = 1'b1;
                        state_nxt    = CHG_REQ;
                    end
                end else begin
                    if (restock)
                        stock_nxt = restock_sum[STOCK_W] ? STOCK_MAX
                                                         : restock_sum[STOCK_W-1:0];
                    if (cash_return != COIN_NONE) begin
                        hop_load  = 1'b1;
                        hop_start = 1'b1;
                        state_nxt = CHG_REQ;
                    end
                end
            end
            VEND: begin
                if (motor_done) begin
                    stock_nxt = stock_level - STOCK_W'(1);
                    if (chg != '0) begin
                        hop_start = 1'b1;
                        state_nxt = CHG_REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timer == TMR_W'(MOTOR_TIMEOUT - 1)) begin
                    // Motor stuck: give the price back and halt after payout.
                    fault_nxt    = 1'b1;
                    hop_load     = 1'b1;
                    hop_load_val = chg + CHG_W'(PRICE);
                    hop_start    = 1'b1;
                    state_nxt    = CHG_REQ;
                end
            end
            CHG_REQ: begin
                if (hopper_ack)
                    state_nxt = CHG_REL;
            end
            CHG_REL: begin
                if (!hopper_ack)
                    state_nxt = hop_done ? (fault ? HALT : IDLE) : CHG_REQ;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= '0;
            stock_level    <= STOCK_W'(STOCK_INIT);
            motor_on       <= 1'b0;
            busy           <= 1'b0;
            coin_accept_en <= 1'b0;
            sold_out       <= (STOCK_INIT == 0);
            fault          <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_nxt;
            // Timer runs only across consecutive VEND cycles.
            timer          <= (state == VEND && state_nxt == VEND) ? timer + TMR_W'(1) : '0;
            stock_level    <= stock_nxt;
            motor_on       <= (state_nxt == VEND);
            busy           <= (state_nxt != IDLE);
            coin_accept_en <= (state_nxt == IDLE) & ~fault_nxt;
            sold_out       <= (stock_nxt == '0);
            fault          <= fault_nxt;
            overrun        <= overrun_nxt;
        end
    end

`ifdef VM_AUDIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sales_count  <= '0;
            refund_count <= '0;
        end else begin
            if (state == VEND && motor_done)
                sales_count <= sales_count + 16'd1;
            if (coin_pulse && hopper_ack)
                refund_count <= refund_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// tb_vm_dispense_ctrl: directed bench for vm_dispense_ctrl with a
// phase-level reference model compared on every cycle, plus literal checks.
module tb_vm_dispense_ctrl;

    localparam int STOCK_W       = 4;
    localparam int STOCK_INIT    = 10;
    localparam int PRICE         = 3;
    localparam int MOTOR_TIMEOUT = 200;
    localparam int STOCK_MAX     = (1 << STOCK_W) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_MOTOR = 1;
    localparam int PH_PAY   = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_DEAD  = 4;

    logic clk, rst, purchase, motor_on, motor_done, coin_pulse, hopper_ack;
    logic coin_accept_en, busy, sold_out, fault, overrun, restock;
    logic [1:0] cash_return;
    logic [STOCK_W-1:0] stock_level, restock_qty;

    int n_tests = 0;
    int n_fails = 0;
    int mon_motor = 0;
    int mon_coins = 0;

    vm_dispense_ctrl #(
        .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT),
        .PRICE(PRICE), .MOTOR_TIMEOUT(MOTOR_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .purchase(purchase), .cash_return(cash_return),
        .motor_on(motor_on), .motor_done(motor_done), .coin_pulse(coin_pulse),
        .hopper_ack(hopper_ack), .coin_accept_en(coin_accept_en), .busy(busy),
        .sold_out(sold_out), .fault(fault), .overrun(overrun),
        .stock_level(stock_level), .restock(restock), .restock_qty(restock_qty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase + owed coins) ----------------
    int m_ph, m_owed, m_stock, m_t;
    bit m_fault, m_ovr, m_live;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= PH_IDLE; m_owed <= 0; m_stock <= STOCK_INIT; m_t <= 0;
            m_fault <= 1'b0; m_ovr <= 1'b0; m_live <= 1'b0;
        end else begin
            m_live <= 1'b1;
            if (m_ph != PH_IDLE && (purchase || cash_return != 0))
                m_ovr <= 1'b1;
            case (m_ph)
                PH_IDLE: begin
                    if (purchase) begin
                        if (restock) m_ovr <= 1'b1;
                        if (m_stock > 0) begin
                            m_ph <= PH_MOTOR; m_t <= 0; m_owed <= cash_return;
                        end else begin
                            m_ph <= PH_PAY; m_owed <= cash_return + PRICE;
                        end
                    end else begin
                        if (restock)
                            m_stock <= (m_stock + restock_qty > STOCK_MAX) ? STOCK_MAX
                                                                           : m_stock + restock_qty;
                        if (cash_return != 0) begin
                            m_ph <= PH_PAY; m_owed <= cash_return;
                        end
                    end
                end
                PH_MOTOR: begin
                    m_t <= m_t + 1;
                    if (motor_done) begin
                        m_stock <= m_stock - 1;
                        m_ph    <= (m_owed > 0) ? PH_PAY : PH_IDLE;
                    end else if (m_t + 1 >= MOTOR_TIMEOUT) begin
                        m_fault <= 1'b1; m_owed <= m_owed + PRICE; m_ph <= PH_PAY;
                    end
                end
                PH_PAY:  if (hopper_ack) begin m_owed <= m_owed - 1; m_ph <= PH_WAIT; end
                PH_WAIT: if (!hopper_ack)
                             m_ph <= (m_owed > 0) ? PH_PAY : (m_fault ? PH_DEAD : PH_IDLE);
                default: ;
            endcase
        end
    end

    // ---------------- monitor + per-cycle compare ----------------
    initial begin
        logic prev_cp;
        prev_cp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (motor_on) mon_motor++;
                if (coin_pulse && !prev_cp) mon_coins++;
                check("motor_on",       motor_on,       m_ph == PH_MOTOR);
                check("coin_pulse",     coin_pulse,     m_ph == PH_PAY);
                check("busy",           busy,           m_ph != PH_IDLE);
                check("coin_accept_en", coin_accept_en, m_live && m_ph == PH_IDLE && !m_fault);
                check("sold_out",       sold_out,       m_stock == 0);
                check("fault",          fault,          m_fault);
                check("overrun",        overrun,        m_ovr);
                check("stock_level",    stock_level,    m_stock);
            end
            prev_cp = coin_pulse;
        end
    end

    // ---------------- hopper responder: ack 2 cycles after request ----------------
    initial begin
        int wait_n;
        wait_n = 0;
        hopper_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (coin_pulse && !hopper_ack) begin
                wait_n++;
                if (wait_n == 2) begin hopper_ack = 1'b1; wait_n = 0; end
            end else begin
                wait_n = 0;
                if (!coin_pulse && hopper_ack) hopper_ack = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin cyc(1); n++; end
        check(name, busy, 0);
    endtask

    task automatic vend(input logic [1:0] cr, input int dly);
        purchase = 1'b1; cash_return = cr;
        cyc(1);
        purchase = 1'b0; cash_return = 2'd0;
        cyc(dly);
        motor_done = 1'b1;
        cyc(1);
        motor_done = 1'b0;
        wait_idle(100, "vend_idle");
    endtask

    task automatic do_restock(input logic [STOCK_W-1:0] q);
        restock = 1'b1; restock_qty = q;
        cyc(1);
        restock = 1'b0; restock_qty = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int m0, c0;
        rst = 1'b0; purchase = 1'b0; cash_return = 2'd0; motor_done = 1'b0;
        restock = 1'b0; restock_qty = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_motor_on", motor_on, 0);
        check("rst_coin_pulse", coin_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_coin_accept_en", coin_accept_en, 0);
        check("rst_stock", stock_level, 10);
        check("rst_fault", fault, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk) rst = 1'b1;
        cyc(1);
        check("idle_coin_accept_en", coin_accept_en, 1);

        // Plain vend: motor_done 5 cycles after purchase clears.
        m0 = mon_motor; c0 = mon_coins;
        vend(2'd0, 5);
        check("t1_motor_cycles", mon_motor - m0, 6);
        check("t1_stock", stock_level, 9);
        check("t1_coins", mon_coins - c0, 0);
        check("t1_coin_accept_en", coin_accept_en, 1);

        // Vend plus one coin of change.
        m0 = mon_motor; c0 = mon_coins;
        vend(2'd1, 2);
        check("t2_coins", mon_coins - c0, 1);
        check("t2_stock", stock_level, 8);

        // Drain stock, then buy while sold out: full refund, no motor.
        for (int i = 0; i < 8; i++) vend(2'd0, 1);
        check("t3_stock_zero", stock_level, 0);
        check("t3_sold_out", sold_out, 1);
        m0 = mon_motor; c0 = mon_coins;
        purchase = 1'b1;
        cyc(1);
        purchase = 1'b0;
        wait_idle(100, "t3_idle");
        check("t3_motor_cycles", mon_motor - m0, 0);
        check("t3_coins", mon_coins - c0, 3);
        check("t3_sold_out_after", sold_out, 1);

        // Restock, then saturate.
        do_restock(4'd9);
        check("t5_restock9", stock_level, 9);
        do_restock(4'd15);
        check("t5_restock_sat", stock_level, 15);
        check("t5_sold_out", sold_out, 0);

        // Change-only, with a purchase dropped while the hopper is busy.
        c0 = mon_coins; m0 = mon_motor;
        cash_return = 2'd2;
        cyc(1);
        cash_return = 2'd0;
        check("t5_pulse_up", coin_pulse, 1);
        purchase = 1'b1;
        cyc(1);
        purchase = 1'b0;
        wait_idle(100, "t5_idle");
        check("t5_overrun", overrun, 1);
        check("t5_coins", mon_coins - c0, 2);
        check("t5_motor", mon_motor - m0, 0);
        check("t5_stock", stock_level, 15);

        // Motor never finishes: timeout, refund, halt.
        c0 = mon_coins; m0 = mon_motor;
        purchase = 1'b1;
        cyc(1);
        purchase = 1'b0;
        cyc(260);
        check("t4_motor_cycles", mon_motor - m0, 200);
        check("t4_coins", mon_coins - c0, 3);
        check("t4_fault", fault, 1);
        check("t4_halt_busy", busy, 1);
        check("t4_halt_coin_accept_en", coin_accept_en, 0);
        check("t4_stock", stock_level, 15);
        purchase = 1'b1;
        cyc(1);
        purchase = 1'b0;
        cyc(3);
        check("t4_still_halt", busy, 1);

        // Reset out of HALT, then async reset mid-handshake.
        @(negedge clk) rst = 1'b0;
        #1;
        check("t6_fault_clr", fault, 0);
        @(negedge clk) rst = 1'b1;
        cyc(1);
        cash_return = 2'd3;
        cyc(1);
        cash_return = 2'd0;
        check("t6_pulse_up", coin_pulse, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_pulse_async", coin_pulse, 0);
        check("t6_busy", busy, 0);
        check("t6_stock", stock_level, STOCK_INIT);
        check("t6_fault", fault, 0);
        check("t6_overrun", overrun, 0);
        @(negedge clk) rst = 1'b1;
        cyc(2);

        // Restock together with purchase: purchase wins.
        purchase = 1'b1; restock = 1'b1; restock_qty = 4'd5;
        cyc(1);
        purchase = 1'b0; restock = 1'b0; restock_qty = '0;
        cyc(2);
        motor_done = 1'b1;
        cyc(1);
        motor_done = 1'b0;
        wait_idle(100, "t7_idle");
        check("t7_stock", stock_level, 9);
        check("t7_overrun", overrun, 1);
        check("t7_coin_accept_en", coin_accept_en, 1);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/vm_dispense_ctrl.md
Name: vm_dispense_ctrl

Overview:
- Controller behind the vending FSM.
- Consumes its one-cycle purchase and cash_return results and sequences the product-dispense motor and the change hopper.
- Tracks stock, refunds on sold-out or motor failure, and throttles coin acceptance (coin_accept_en) while a transaction is in flight.

Parameters:
STOCK_W, 4, width of stock counter
STOCK_INIT, 10, stock level after reset (≤ 2^STOCK_W−1)
PRICE, 3, item price in coin units; refunded on sold-out or fault
MOTOR_TIMEOUT, 200, max cycles motor_on may stay high without motor_done

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
purchase  in  1  one-cycle pulse from vending FSM: item paid
cash_return  in  2  change owed in coin units (0–3), valid with purchase or alone
motor_on  out  1  dispense motor drive
motor_done  in  1  motor end-of-travel sensor, level
coin_pulse  out  1  hopper request, one coin per 4-phase handshake
hopper_ack  in  1  hopper acknowledge
coin_accept_en  out  1  upstream may accept coins
busy  out  1  transaction in progress
sold_out  out  1  stock_level == 0
fault  out  1  sticky motor-timeout fault
overrun  out  1  sticky: event arrived while busy
stock_level  out  STOCK_W  current stock
restock  in  1  pulse: add restock_qty
restock_qty  in  STOCK_W  units to add

Behaviour:
- Reset (rst=0, async):
  - motor_on, coin_pulse, busy, fault, overrun, coin_accept_en = 0.
  - stock_level = STOCK_INIT; change counter = 0; state IDLE.
- All outputs registered. coin_accept_en = (state==IDLE) & !fault.
- States:
  - IDLE, VEND, CHG_REQ, CHG_REL, HALT.
- IDLE: on cycle N with purchase=1:
  - stock>0: chg ← cash_return; state VEND; motor_on=1 at N+1.
  - stock==0: chg ← cash_return+PRICE (3-bit, max 6); state CHG_REQ; no motor.
- IDLE: cash_return≠0 without purchase:
  - chg ← cash_return; state CHG_REQ.
- IDLE, nothing pending: purchase=0 and cash_return=0 → stay IDLE.
- VEND: timer counts from 0 each cycle.
  - motor_done=1: motor_on←0; stock_level−1.
    - chg≠0 → CHG_REQ; chg==0 → IDLE.
  - timer reaches MOTOR_TIMEOUT: motor_on←0; fault←1; chg←chg+PRICE; stock unchanged → CHG_REQ.
- CHG_REQ: coin_pulse=1; wait hopper_ack=1 → coin_pulse←0, chg−1 → CHG_REL.
- CHG_REL: wait hopper_ack=0.
  - chg≠0 → CHG_REQ.
  - chg==0 → IDLE if !fault, HALT if fault.
- HALT: motor and hopper idle, coin_accept_en=0; leaves only via reset.
- busy = (state≠IDLE).
- purchase or cash_return≠0 while busy (or in HALT):
  - Event dropped; overrun←1 (sticky until reset).
- restock: accepted only in IDLE, same cycle as no purchase.
  - stock ← min(stock+restock_qty, 2^STOCK_W−1), saturating.
  - restock together with purchase: purchase wins; restock dropped, overrun←1.
- Simultaneous purchase=1, cash_return=2'b01: vend first, then 1 coin.
- Reset mid-handshake: coin_pulse drops immediately; owed change lost (documented limitation).

Optional Feature:
- VM_AUDIT_EN:
  - Defined: adds outputs sales_count[15:0] (incremented on each successful motor_done) and refund_count[15:0] (incremented per coin paid out). Both wrap at 16'hFFFF→0 and reset to 0.
  - Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package vm_pkg:
  - State encoding enum.
  - Coin-unit codes (COIN_NONE=0, COIN_1=1, COIN_2=2).
  - PRICE default.
  - Change-counter width constant (3).
- Sub-module vm_hopper_if:
  - Owns the 4-phase coin_pulse/hopper_ack handshake and change down-counter.
  - Interface: load value, start, done.

Test Plan:
- Reset release, stock=10, purchase + cash_return=0, motor_done 5 cycles later → motor_on at N+1 for 6 cycles; stock 9; coin_accept_en low during, high after.
- purchase + cash_return=2'b01; hopper ack 2 cycles after each pulse → vend, then exactly one coin_pulse handshake; busy clears after hopper_ack falls.
- stock driven to 0, then purchase + cash_return=0 → no motor_on; 3 coin_pulse handshakes; sold_out=1 throughout.
- motor_done held 0 → motor_on drops after 200 cycles; fault=1; 3 refund coins; HALT with coin_accept_en=0; stock unchanged.
- purchase during CHG_REQ → dropped, overrun=1, coin count unchanged; restock_qty=15 at stock=9 → stock_level=15 (saturate).
- rst asserted while coin_pulse=1 → coin_pulse=0 same cycle asynchronously; stock=STOCK_INIT; fault and overrun cleared.
